mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
Shares the single-port 32x32 scratch memory between the Wishbone slave port and the ASCON engine port (the memory controller's port).
- Arbitrates every cycle; the engine normally has priority.
- A starvation counter guarantees Wishbone forward progress.
- An engine lock input makes a multi-cycle engine burst atomic.

Parameters:
ADDR_W, 5, memory address width
DATA_W, 32, memory word width
MAX_WAIT, 8, cycles a pending WB request may be denied before it is forced to win (1..15)
CNT_W, 4, width of the wait counter; must hold MAX_WAIT

Ports:
clk  in  1  system clock
nRST  in  1  reset, synchronous, active-low
wb_cyc  in  1  WB cycle valid
wb_stb  in  1  WB strobe
wb_we  in  1  WB write enable (1 = write)
wb_addr  in  ADDR_W  WB word address
wb_dat_i  in  DATA_W  WB write data
wb_dat_o  out  DATA_W  WB read data, valid with wb_ack
wb_ack  out  1  WB acknowledge, one-cycle pulse
eng_req  in  1  engine requests memory this cycle
eng_lock  in  1  engine holds the port; WB is never granted while high
eng_we  in  1  engine write enable, active-low (0 = write)
eng_addr  in  ADDR_W  engine address
eng_datain  in  DATA_W  engine write data
eng_gnt  out  1  engine owns the memory port this cycle (combinational)
eng_rvalid  out  1  read data for the previous granted engine read is on eng_dataout
eng_dataout  out  DATA_W  memory read data (mem_dataout pass-through)
mem_we  out  1  memory write enable, active-low
mem_addr  out  ADDR_W  memory address
mem_datain  out  DATA_W  memory write data
mem_dataout  in  DATA_W  memory read data, registered; valid the cycle after the address

Behaviour:
- Memory timing:
  - Write commits at the clock edge ending the cycle in which mem_we=0.
  - Read data appears on mem_dataout one cycle after mem_addr is presented.
- FSM states:
  - IDLE: WB eligible for grant.
  - WB_ACK: WB access in flight; WB not eligible.
- Definitions:
  - wb_pend = wb_cyc & wb_stb & (state==IDLE).
  - wb_force = (wait_cnt == MAX_WAIT).
- Grant, evaluated every cycle:
  - WB is granted when wb_pend & !eng_lock & (!eng_req | wb_force).
  - Otherwise the engine is granted when eng_req (eng_gnt=1).
  - Otherwise the port is idle: mem_we=1, mem_addr=0, mem_datain=0.
- Port drive:
  - Engine grant: mem_we = eng_we; mem_addr/mem_datain from the eng_* inputs.
  - WB grant: mem_we = !wb_we; mem_addr = wb_addr; mem_datain = wb_dat_i; next state = WB_ACK.
  - A denied engine request keeps eng_gnt=0; the engine must hold its request and retry.
- WB_ACK state:
  - wb_ack=1.
  - wb_dat_o = mem_dataout for reads; 0 for writes (registered we flag).
  - Returns to IDLE unconditionally.
  - The engine may be granted during WB_ACK.
  - WB access latency is exactly 1 cycle grant-to-ack. Minimum WB spacing is 2 cycles, because a stb still high in the ack cycle is not re-granted.
- Engine read data:
  - eng_rvalid registered = eng_gnt & eng_we of the previous cycle.
  - eng_dataout = mem_dataout.
- wait_cnt:
  - Increments, saturating at MAX_WAIT, when wb_pend and WB is not granted.
  - Clears on WB grant, or when wb_cyc=0 in IDLE.
  - Holds (does not clear) while eng_lock is high; wb_force stays ready for lock release.
- Abort cases:
  - wb_cyc falls while a request is pending and not granted: the request is dropped, no ack, counter cleared.
  - wb_cyc falls during WB_ACK: the ack is still issued.
- Simultaneous events:
  - eng_req & wb_pend with wb_force & !eng_lock: WB wins and eng_gnt=0 that cycle.
  - eng_lock=1 with eng_req=0: the port stays idle and WB is still blocked.
- Reset (nRST=0 at posedge):
  - Next state: IDLE, wait_cnt=0, wb_ack=0, eng_rvalid=0, stored we flag=0.
  - While nRST=0, all grants are forced to 0 and mem_we=1, so nothing is written during reset.
  - Reset asserted mid-WB access drops the ack.

Decomposition:
- Shared package ascon_pkg:
  - arb_state_t enum {IDLE, WB_ACK}.
  - MEM_ADDR_W=5 and MEM_DATA_W=32 constants.
- Sub-module arb_wait_cnt: saturating counter with inc/clr/hold controls and full flag. Everything else stays in one always_ff and one always_comb.

Test Plan:
- WB write then read, no engine traffic.
  - Write addr 3 = 0xDEADBEEF: mem_we=0 in the grant cycle, wb_ack the next cycle.
  - Read addr 3: wb_ack one cycle after grant with wb_dat_o=0xDEADBEEF.
- Engine priority: eng_req held high, WB read pending.
  - WB is denied for exactly MAX_WAIT=8 cycles.
  - Cycle 9: WB granted and eng_gnt=0.
  - Cycle 10: wb_ack; engine regranted.
- Engine lock: eng_lock high for 20 cycles with a WB request pending.
  - No WB grant during lock; wait_cnt saturates at 8.
  - WB is granted in the first cycle after lock release, even with eng_req=1.
- Engine burst read of addrs 0..3 (preloaded 0x10..0x13): eng_rvalid follows each grant by 1 cycle with the matching data; no bubbles when WB is idle.
- WB abort: stb pending while denied, then wb_cyc drops → no ack, no memory write, wait_cnt=0.
- Reset during WB_ACK and during an engine write → no ack afterwards, mem_we=1 throughout reset, target word unchanged.

Source files
------------

// File: rtl/ascon_pkg.sv
// rtl/ascon_pkg.sv - shared arbiter state type and scratch memory geometry
package ascon_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    WB_ACK = 1'b1
  } arb_state_t;

  localparam int MEM_ADDR_W = 5;
  localparam int MEM_DATA_W = 32;

endpackage

// File: rtl/arb_wait_cnt.sv
// rtl/arb_wait_cnt.sv - saturating wait counter; hold blocks clearing but not counting
module arb_wait_cnt
  import ascon_pkg::*;
#(
  parameter int CNT_W    = 4,
  parameter int MAX_WAIT = 8
) (
  input  logic clk,
  input  logic nRST,
  input  logic inc,
  input  logic clr,
  input  logic hold,
  output logic full
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0] cnt;

  assign full = (cnt == MAX_CNT);

  // Holding keeps the count armed across an engine lock so the waiting
  // Wishbone request wins as soon as the lock drops.
  always_ff @(posedge clk) begin
    if (!nRST) begin
      cnt <= '0;
    end else if (clr && !hold) begin
      cnt <= '0;
    end else if (inc && !full) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - scratch memory port arbiter between Wishbone slave and ASCON engine
module mem_arbiter
  import ascon_pkg::*;
#(
  parameter int ADDR_W   = MEM_ADDR_W,
  parameter int DATA_W   = MEM_DATA_W,
  parameter int MAX_WAIT = 8,
  parameter int CNT_W    = 4
) (
  input  logic              clk,
  input  logic              nRST,
  input  logic              wb_cyc,
  input  logic              wb_stb,
  input  logic              wb_we,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_dat_i,
  output logic [DATA_W-1:0] wb_dat_o,
  output logic              wb_ack,
  input  logic              eng_req,
  input  logic              eng_lock,
  input  logic              eng_we,
  input  logic [ADDR_W-1:0] eng_addr,
  input  logic [DATA_W-1:0] eng_datain,
  output logic              eng_gnt,
  output logic              eng_rvalid,
  output logic [DATA_W-1:0] eng_dataout,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_datain,
  input  logic [DATA_W-1:0] mem_dataout
);

  arb_state_t state, state_nx;
  logic       wb_we_q;
  logic       wb_pend;
  logic       wb_force;
  logic       wb_gnt;

  arb_wait_cnt #(
    .CNT_W   (CNT_W),
    .MAX_WAIT(MAX_WAIT)
  ) u_wait_cnt (
    .clk (clk),
    .nRST(nRST),
    .inc (wb_pend && !wb_gnt),
    .clr (wb_gnt || ((state == IDLE) && !wb_cyc)),
    .hold(eng_lock),
    .full(wb_force)
  );

  always_ff @(posedge clk) begin
    if (!nRST) begin
      state      <= IDLE;
      wb_we_q    <= 1'b0;
      eng_rvalid <= 1'b0;
    end else begin
      state      <= state_nx;
      eng_rvalid <= eng_gnt && eng_we;
      if (wb_gnt) begin
        wb_we_q <= wb_we;
      end
    end
  end

  // Grants are gated by nRST so the memory never sees a write during reset.
  always_comb begin
    state_nx   = IDLE;
    wb_gnt     = 1'b0;
    eng_gnt    = 1'b0;
    mem_we     = 1'b1;
    mem_addr   = '0;
    mem_datain = '0;
    wb_pend    = wb_cyc && wb_stb && (state == IDLE);
    if (nRST && wb_pend && !eng_lock && (!eng_req || wb_force)) begin
      wb_gnt = 1'b1;
    end else if (nRST && eng_req) begin
      eng_gnt = 1'b1;
    end
    if (wb_gnt) begin
      mem_we     = !wb_we;
      mem_addr   = wb_addr;
      mem_datain = wb_dat_i;
      state_nx   = WB_ACK;
    end else if (eng_gnt) begin
      mem_we     = eng_we;
      mem_addr   = eng_addr;
      mem_datain = eng_datain;
    end
  end

  assign wb_ack      = (state == WB_ACK);
  assign wb_dat_o    = (wb_ack && !wb_we_q) ? mem_dataout : '0;
  assign eng_dataout = mem_dataout;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed bench with behavioural arbiter model and scratch memory
module tb_mem_arbiter;

  localparam int MAXW = 8;

  logic        clk;
  logic        nRST;
  logic        wb_cyc, wb_stb, wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_dat_i, wb_dat_o;
  logic        wb_ack;
  logic        eng_req, eng_lock, eng_we;
  logic [4:0]  eng_addr;
  logic [31:0] eng_datain, eng_dataout;
  logic        eng_gnt, eng_rvalid;
  logic        mem_we;
  logic [4:0]  mem_addr;
  logic [31:0] mem_datain, mem_dataout;

  int total = 0;
  int bad   = 0;

  mem_arbiter dut (
    .clk        (clk),
    .nRST       (nRST),
    .wb_cyc     (wb_cyc),
    .wb_stb     (wb_stb),
    .wb_we      (wb_we),
    .wb_addr    (wb_addr),
    .wb_dat_i   (wb_dat_i),
    .wb_dat_o   (wb_dat_o),
    .wb_ack     (wb_ack),
    .eng_req    (eng_req),
    .eng_lock   (eng_lock),
    .eng_we     (eng_we),
    .eng_addr   (eng_addr),
    .eng_datain (eng_datain),
    .eng_gnt    (eng_gnt),
    .eng_rvalid (eng_rvalid),
    .eng_dataout(eng_dataout),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_datain (mem_datain),
    .mem_dataout(mem_dataout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scratch memory: write at edge when mem_we=0, registered read
  logic [31:0] ram [32];
  always @(posedge clk) begin
    if (!mem_we) ram[mem_addr] <= mem_datain;
    mem_dataout <= ram[mem_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model: who owns the port, how long WB has waited, what data is due
  logic [31:0] shadow [32];
  bit          m_live = 0;
  bit          m_busy, m_busy_wr, m_rv;
  int          m_wait;
  logic [31:0] m_busy_rd, m_rv_data;
  bit          n_busy, n_busy_wr, n_rv;
  int          n_wait;
  logic [31:0] n_busy_rd, n_rv_data;
  bit          n_wr_en;
  logic [4:0]  n_wr_addr;
  logic [31:0] n_wr_data;
  bit          pend, wb_win, eng_win;
  logic        e_we;
  logic [4:0]  e_addr;
  logic [31:0] e_din;

  always @(negedge clk) begin
    if (m_live) begin
      pend    = wb_cyc && wb_stb && !m_busy;
      wb_win  = nRST && pend && !eng_lock && (!eng_req || m_wait == MAXW);
      eng_win = nRST && eng_req && !wb_win;
      e_we = 1'b1; e_addr = '0; e_din = '0;
      if (wb_win) begin
        e_we = !wb_we; e_addr = wb_addr; e_din = wb_dat_i;
      end else if (eng_win) begin
        e_we = eng_we; e_addr = eng_addr; e_din = eng_datain;
      end
      chk("eng_gnt", eng_gnt, eng_win);
      chk("wb_ack", wb_ack, m_busy);
      chk("wb_dat_o", wb_dat_o, (m_busy && !m_busy_wr) ? m_busy_rd : 32'h0);
      chk("mem_we", mem_we, e_we);
      chk("mem_addr", mem_addr, e_addr);
      chk("mem_datain", mem_datain, e_din);
      chk("eng_rvalid", eng_rvalid, m_rv);
      if (m_rv) chk("eng_dataout", eng_dataout, m_rv_data);
    end
    n_wr_en = 0; n_wr_addr = '0; n_wr_data = '0;
    if (!nRST) begin
      n_busy = 0; n_busy_wr = 0; n_busy_rd = '0; n_rv = 0; n_rv_data = '0; n_wait = 0;
    end else begin
      n_busy    = wb_win;
      n_busy_wr = wb_win ? wb_we : m_busy_wr;
      n_busy_rd = shadow[wb_addr];
      n_rv      = eng_win && eng_we;
      n_rv_data = shadow[eng_addr];
      if (wb_win && wb_we) begin
        n_wr_en = 1; n_wr_addr = wb_addr; n_wr_data = wb_dat_i;
      end else if (eng_win && !eng_we) begin
        n_wr_en = 1; n_wr_addr = eng_addr; n_wr_data = eng_datain;
      end
      if (wb_win) n_wait = 0;
      else if (!m_busy && !wb_cyc && !eng_lock) n_wait = 0;
      else if (pend) n_wait = (m_wait < MAXW) ? m_wait + 1 : MAXW;
      else n_wait = m_wait;
    end
  end

  always @(posedge clk) begin
    if (!nRST) m_live <= 1;
    m_busy    <= n_busy;
    m_busy_wr <= n_busy_wr;
    m_busy_rd <= n_busy_rd;
    m_rv      <= n_rv;
    m_rv_data <= n_rv_data;
    m_wait    <= n_wait;
    if (m_live && n_wr_en) shadow[n_wr_addr] <= n_wr_data;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb_set(input logic c, input logic s, input logic w, input logic [4:0] a,
                        input logic [31:0] d);
    wb_cyc = c; wb_stb = s; wb_we = w; wb_addr = a; wb_dat_i = d;
  endtask

  task automatic eng_set(input logic r, input logic l, input logic w, input logic [4:0] a,
                         input logic [31:0] d);
    eng_req = r; eng_lock = l; eng_we = w; eng_addr = a; eng_datain = d;
  endtask

  int n;

  initial begin
    for (int i = 0; i < 32; i++) begin
      ram[i] = 32'h0;
      shadow[i] = 32'h0;
    end
    m_busy = 0; m_busy_wr = 0; m_rv = 0; m_wait = 0; m_busy_rd = '0; m_rv_data = '0;
    nRST = 1'b0;
    wb_set(0, 0, 0, 0, 0);
    eng_set(1, 0, 0, 2, 32'hBAD);
    repeat (2) begin
      @(negedge clk);
      chk("rst_mem_we", mem_we, 1);
      chk("rst_eng_gnt", eng_gnt, 0);
      tick();
    end
    nRST = 1'b1;
    eng_set(0, 0, 1, 0, 0);
    @(negedge clk);
    chk("rst_wb_ack", wb_ack, 0);
    tick();

    // WB write then read
    wb_set(1, 1, 1, 3, 32'hDEADBEEF);
    @(negedge clk);
    chk("wr_mem_we", mem_we, 0);
    chk("wr_mem_addr", mem_addr, 3);
    tick();
    wb_set(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("wr_ack", wb_ack, 1);
    tick();
    wb_set(1, 1, 0, 3, 0);
    @(negedge clk);
    chk("rd_no_ack_yet", wb_ack, 0);
    tick();
    wb_set(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("rd_ack", wb_ack, 1);
    chk("rd_data", wb_dat_o, 32'hDEADBEEF);
    tick();

    // engine priority with starvation limit
    eng_set(1, 0, 1, 5, 0);
    wb_set(1, 1, 0, 3, 0);
    n = 0;
    repeat (8) begin
      @(negedge clk);
      n = n + int'(eng_gnt);
      tick();
    end
    chk("pri_denied_cycles", n, 8);
    @(negedge clk);
    chk("pri_wb_wins", eng_gnt, 0);
    chk("pri_wb_addr", mem_addr, 3);
    tick();
    @(negedge clk);
    chk("pri_ack", wb_ack, 1);
    chk("pri_eng_regrant", eng_gnt, 1);
    chk("pri_data", wb_dat_o, 32'hDEADBEEF);
    tick();
    @(negedge clk);
    chk("pri_stb_not_regranted", eng_gnt, 1);
    tick();
    wb_set(0, 0, 0, 0, 0);
    eng_set(0, 0, 1, 0, 0);
    tick();

    // engine lock blocks WB for 20 cycles
    wb_set(1, 1, 0, 3, 0);
    eng_set(1, 1, 1, 6, 0);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (i == 10) eng_req = 1'b0;
      @(negedge clk);
      n = n + int'(wb_ack);
      tick();
    end
    chk("lock_no_ack", n, 0);
    eng_set(1, 0, 1, 6, 0);
    @(negedge clk);
    chk("lock_release_wb_wins", eng_gnt, 0);
    chk("lock_release_addr", mem_addr, 3);
    tick();
    @(negedge clk);
    chk("lock_release_ack", wb_ack, 1);
    tick();
    wb_set(0, 0, 0, 0, 0);
    eng_set(0, 0, 1, 0, 0);
    tick();

    // engine preload and back-to-back burst read
    for (int i = 0; i < 4; i++) begin
      eng_set(1, 0, 0, 5'(i), 32'h10 + 32'(i));
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      eng_set(1, 0, 1, 5'(i), 0);
      @(negedge clk);
      chk("burst_gnt", eng_gnt, 1);
      if (i > 0) begin
        chk("burst_rvalid", eng_rvalid, 1);
        chk("burst_data", eng_dataout, 32'h10 + 32'(i - 1));
      end
      tick();
    end
    eng_set(0, 0, 1, 0, 0);
    @(negedge clk);
    chk("burst_rvalid_last", eng_rvalid, 1);
    chk("burst_data_last", eng_dataout, 32'h13);
    tick();
    @(negedge clk);
    chk("burst_rvalid_end", eng_rvalid, 0);
    tick();

    // WB abort while denied
    eng_set(1, 0, 1, 7, 0);
    wb_set(1, 1, 1, 9, 32'h55);
    repeat (3) tick();
    wb_set(0, 1, 1, 9, 32'h55);
    tick();
    wb_set(0, 0, 0, 0, 0);
    eng_set(0, 0, 1, 0, 0);
    n = 0;
    repeat (3) begin
      @(negedge clk);
      n = n + int'(wb_ack);
      tick();
    end
    chk("abort_no_ack", n, 0);
    eng_set(1, 0, 1, 7, 0);
    wb_set(1, 1, 0, 9, 0);
    n = 0;
    repeat (8) begin
      @(negedge clk);
      n = n + int'(eng_gnt);
      tick();
    end
    chk("abort_wait_restarted", n, 8);
    @(negedge clk);
    chk("abort_regrant", eng_gnt, 0);
    tick();
    wb_set(0, 0, 0, 0, 0);
    eng_set(0, 0, 1, 0, 0);
    @(negedge clk);
    chk("abort_ack", wb_ack, 1);
    chk("abort_no_write", wb_dat_o, 32'h0);
    tick();

    // reset during WB ack and during an engine write
    wb_set(1, 1, 1, 10, 32'hA5A5A5A5);
    tick();
    nRST = 1'b0;
    eng_set(1, 0, 0, 11, 32'h77);
    repeat (2) begin
      @(negedge clk);
      chk("rst2_mem_we", mem_we, 1);
      chk("rst2_eng_gnt", eng_gnt, 0);
      tick();
    end
    nRST = 1'b1;
    wb_set(0, 0, 0, 0, 0);
    eng_set(0, 0, 1, 0, 0);
    @(negedge clk);
    chk("rst2_no_ack", wb_ack, 0);
    tick();
    wb_set(1, 1, 0, 11, 0);
    tick();
    wb_set(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("rst2_word_unchanged", wb_dat_o, 32'h0);
    tick();
    wb_set(1, 1, 0, 10, 0);
    tick();
    wb_set(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("rst2_wb_write_kept", wb_dat_o, 32'hA5A5A5A5);
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
